// File: rtl/dmem_responder_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dmem_responder_if : load/store request + response channels to data memory |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dmem_responder : single-outstanding data memory with fixed access latency |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module dmem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst,
  dmem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          write_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic          req_ready_q;
  logic          resp_valid_q;
  logic          resp_err_q;
  logic [31:0]   resp_rdata_q;
  logic [31:0]   mem_q [DEPTH];

  logic [AW-1:0] idx;
  logic          addr_err;
  logic          access_now;
  logic          mem_we;

  assign idx        = addr_q[AW+1:2];
  assign addr_err   = (addr_q[1:0] != 2'b00) || ((addr_q >> (AW + 2)) != 32'd0);
  assign access_now = (state_q == WAIT) && (cnt_q == '0);
  assign mem_we     = access_now && write_q && !addr_err;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid && req_ready_q) begin
            write_q     <= bus.req_write;
            addr_q      <= bus.req_addr;
            wdata_q     <= bus.req_wdata;
            cnt_q       <= CW'(LATENCY - 1);
            req_ready_q <= 1'b0;
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          // Access happens on the edge LATENCY cycles after the accept edge
          if (cnt_q == '0) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= addr_err;
            resp_rdata_q <= (write_q || addr_err) ? 32'd0 : mem_q[idx];
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            req_ready_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Gated by rst so a store still waiting when reset hits is never committed
  always_ff @(posedge clk) begin
    if (rst && mem_we) begin
      mem_q[idx] <= wdata_q;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dmem_responder : scoreboard bench, LATENCY=2 (A) and LATENCY=1 (B)     |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module tb_dmem_responder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dmem_responder_if ifa ();
  dmem_responder_if ifb ();

  dmem_responder #(.DEPTH(64), .LATENCY(2)) u_a (.clk(clk), .rst(rst), .bus(ifa));
  dmem_responder #(.DEPTH(64), .LATENCY(1)) u_b (.clk(clk), .rst(rst), .bus(ifb));

  logic [1:0]  v, w, rr;
  logic [31:0] ad [2];
  logic [31:0] wd [2];
  logic [1:0]  rdy, rv, er;
  logic [31:0] rd [2];

  assign ifa.req_valid  = v[0];
  assign ifa.req_write  = w[0];
  assign ifa.req_addr   = ad[0];
  assign ifa.req_wdata  = wd[0];
  assign ifa.resp_ready = rr[0];
  assign ifb.req_valid  = v[1];
  assign ifb.req_write  = w[1];
  assign ifb.req_addr   = ad[1];
  assign ifb.req_wdata  = wd[1];
  assign ifb.resp_ready = rr[1];
  assign rdy[0] = ifa.req_ready;
  assign rv[0]  = ifa.resp_valid;
  assign er[0]  = ifa.resp_err;
  assign rd[0]  = ifa.resp_rdata;
  assign rdy[1] = ifb.req_ready;
  assign rv[1]  = ifb.resp_valid;
  assign er[1]  = ifb.resp_err;
  assign rd[1]  = ifb.resp_rdata;

  int n_vec  = 0;
  int n_fail = 0;
  logic [32:0] sb0 [$];
  logic [32:0] sb1 [$];

  function automatic int lat_of(input int s);
    return (s == 0) ? 2 : 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic push(input int s, input logic [31:0] r, input logic e);
    if (s == 0) sb0.push_back({e, r});
    else        sb1.push_back({e, r});
  endtask

  // Monitor: one pop per response handshake (valid & ready seen mid-cycle)
  always @(negedge clk) begin : mon
    logic [32:0] exp_v;
    logic        have;
    for (int s = 0; s < 2; s++) begin
      if (rst && rv[s] && rr[s]) begin
        have = 1'b0;
        exp_v = '0;
        if (s == 0 && sb0.size() > 0) begin exp_v = sb0.pop_front(); have = 1'b1; end
        if (s == 1 && sb1.size() > 0) begin exp_v = sb1.pop_front(); have = 1'b1; end
        n_vec++;
        if (!have) begin
          n_fail++;
          $display("FAIL resp%0d unexpected: rdata=%h err=%b, expected no response", s, rd[s], er[s]);
        end else if ({er[s], rd[s]} !== exp_v) begin
          n_fail++;
          $display("FAIL resp%0d: rdata=%h err=%b, expected rdata=%h err=%b",
                   s, rd[s], er[s], exp_v[31:0], exp_v[32]);
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the accept edge.
  task automatic accept(input int s, input logic wr, input logic [31:0] a, input logic [31:0] d);
    logic ok;
    v[s] = 1'b1; w[s] = wr; ad[s] = a; wd[s] = d;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (rdy[s]) begin ok = 1'b1; break; end
    end
    chk("accept within bound", 32'(ok), 32'd1);
    @(posedge clk); #1;
    v[s] = 1'b0;
  endtask

  // Returns on the falling edge where resp_valid is first seen.
  task automatic wait_resp(input int s, output int lat, output int lowc);
    lat = 0; lowc = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (!rdy[s]) lowc++;
      if (rv[s]) break;
      lat++;
    end
  endtask

  task automatic tx(input int s, input logic wr, input logic [31:0] a, input logic [31:0] d,
                    input logic [31:0] exp_rd, input logic exp_err);
    int lat, lowc;
    accept(s, wr, a, d);
    push(s, exp_rd, exp_err);
    wait_resp(s, lat, lowc);
    chk("resp latency", 32'(lat), 32'(lat_of(s)));
    @(negedge clk);
    chk("req_ready low cycles", 32'(lowc), 32'(lat_of(s) + 1));
    chk("req_ready back after handshake", 32'(rdy[s]), 32'd1);
    @(posedge clk); #1;
  endtask

  int lat_v, low_v;
  int cyc, acc_cnt, resp_cnt, last_acc;
  logic pend, acc_now;
  logic [31:0] b_addr [3];
  logic [31:0] b_exp  [3];

  initial begin
    v = '0; w = '0; rr = 2'b11;
    for (int s = 0; s < 2; s++) begin ad[s] = '0; wd[s] = '0; end
    b_addr[0] = 32'd0;     b_addr[1] = 32'd4;     b_addr[2] = 32'd8;
    b_exp[0]  = 32'h11;    b_exp[1]  = 32'h22;    b_exp[2]  = 32'h33;

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("reset req_ready", 32'(rdy[s]), 32'd1);
      chk("reset resp_valid", 32'(rv[s]), 32'd0);
      chk("reset resp_rdata", rd[s], 32'd0);
      chk("reset resp_err", 32'(er[s]), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b1;

    // Store then load through the same word
    tx(0, 1'b1, 32'd16, 32'd42, 32'd0, 1'b0);
    tx(0, 1'b0, 32'd16, 32'd0, 32'd42, 1'b0);
    tx(0, 1'b1, 32'd0,  32'h1234, 32'd0, 1'b0);
    tx(0, 1'b1, 32'd20, 32'd8, 32'd0, 1'b0);
    tx(0, 1'b1, 32'd8,  32'd7, 32'd0, 1'b0);

    // Error paths must not touch memory
    tx(0, 1'b0, 32'h0000_000E, 32'd0, 32'd0, 1'b1);
    tx(0, 1'b1, 32'd256, 32'hDEAD, 32'd0, 1'b1);
    tx(0, 1'b0, 32'h8000_0010, 32'd0, 32'd0, 1'b1);
    tx(0, 1'b0, 32'd0, 32'd0, 32'h1234, 1'b0);

    // Backpressure on a load of word 5
    rr[0] = 1'b0;
    accept(0, 1'b0, 32'd20, 32'd0);
    push(0, 32'd8, 1'b0);
    wait_resp(0, lat_v, low_v);
    chk("bp latency", 32'(lat_v), 32'd2);
    v[0] = 1'b1; w[0] = 1'b1; ad[0] = 32'd16; wd[0] = 32'hBAD;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      chk("bp resp_valid held", 32'(rv[0]), 32'd1);
      chk("bp rdata held", rd[0], 32'd8);
      chk("bp req_ready low", 32'(rdy[0]), 32'd0);
    end
    @(posedge clk); #1;
    rr[0] = 1'b1; w[0] = 1'b0;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("bp ready after handshake", 32'(rdy[0]), 32'd1);
    chk("bp valid cleared", 32'(rv[0]), 32'd0);
    chk("bp rdata cleared", rd[0], 32'd0);
    @(posedge clk); #1;
    v[0] = 1'b0;
    push(0, 32'd42, 1'b0);
    wait_resp(0, lat_v, low_v);
    chk("bp next accept latency", 32'(lat_v), 32'd2);
    @(posedge clk); #1;

    // Reset while in WAIT drops the store
    accept(0, 1'b1, 32'd8, 32'h55);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("wait-reset resp_valid", 32'(rv[0]), 32'd0);
      chk("wait-reset req_ready", 32'(rdy[0]), 32'd1);
      chk("wait-reset rdata", rd[0], 32'd0);
      chk("wait-reset err", 32'(er[0]), 32'd0);
    end
    @(posedge clk); #1;
    tx(0, 1'b0, 32'd8, 32'd0, 32'd7, 1'b0);

    // Reset while in RESP keeps the committed store
    rr[0] = 1'b0;
    accept(0, 1'b1, 32'd12, 32'h66);
    wait_resp(0, lat_v, low_v);
    chk("resp-reset latency", 32'(lat_v), 32'd2);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("resp-reset resp_valid", 32'(rv[0]), 32'd0);
    chk("resp-reset req_ready", 32'(rdy[0]), 32'd1);
    @(posedge clk); #1;
    rr[0] = 1'b1;
    tx(0, 1'b0, 32'd12, 32'd0, 32'h66, 1'b0);

    // LATENCY=1 instance: preload then back-to-back loads with req_valid held
    for (int i = 0; i < 3; i++) tx(1, 1'b1, b_addr[i], b_exp[i], 32'd0, 1'b0);
    cyc = 0; acc_cnt = 0; resp_cnt = 0; last_acc = -10; pend = 1'b0;
    v[1] = 1'b1; w[1] = 1'b0; ad[1] = b_addr[0];
    for (int g = 0; g < 30 && resp_cnt < 3; g++) begin
      @(negedge clk);
      if (pend && rv[1]) begin
        chk("b2b resp latency", 32'(cyc - last_acc), 32'd1);
        pend = 1'b0;
        resp_cnt++;
      end
      acc_now = v[1] && rdy[1];
      if (acc_now) begin
        if (acc_cnt > 0) chk("b2b accept spacing", 32'(cyc + 1 - last_acc), 32'd3);
        last_acc = cyc + 1;
        push(1, b_exp[acc_cnt], 1'b0);
        pend = 1'b1;
        acc_cnt++;
      end
      @(posedge clk);
      cyc++;
      #1;
      if (acc_now) begin
        if (acc_cnt < 3) ad[1] = b_addr[acc_cnt];
        else             v[1] = 1'b0;
      end
    end
    chk("b2b responses", 32'(resp_cnt), 32'd3);

    repeat (3) @(negedge clk);
    chk("scoreboard A drained", 32'(sb0.size()), 32'd0);
    chk("scoreboard B drained", 32'(sb1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
